// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch unit and the memory.
// The fetch unit drives request/address; the memory answers with ack/data.
interface instr_fetch_if;
   logic        Imem_Req;
   logic [31:0] Imem_Addr;
   logic        Imem_Ack;
   logic [31:0] Imem_Data;

   modport master (
      output Imem_Req,
      output Imem_Addr,
      input  Imem_Ack,
      input  Imem_Data
   );

   modport slave (
      input  Imem_Req,
      input  Imem_Addr,
      output Imem_Ack,
      output Imem_Data
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, requests one word per PC from memory,
// holds it for decode, and latches a sticky error if memory never answers.
module instr_fetch (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          PC_Sel,
   input  logic          PC_LdEn,
   input  logic [31:0]   PC_Immed,
   instr_fetch_if.master imem,
   output logic [31:0]   PC,
   output logic [31:0]   Instr,
   output logic          Instr_Valid,
   output logic          Fetch_Err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      ERR  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] next_pc_s;

   // Sequential PC: the shift drops the top two offset bits, the add wraps mod 2^32.
   always_comb begin
      next_pc_s = pc_q + 32'd4;
      if (PC_Sel) begin
         next_pc_s = pc_q + 32'd4 + (PC_Immed << 2);
      end else begin
         next_pc_s = pc_q + 32'd4;
      end
   end

   // Next-state and next-register decode for the fetch FSM.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      err_d      = err_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            // Ack wins over timeout when both happen on the same edge.
            if (imem.Imem_Ack) begin
               instr_d    = imem.Imem_Data;
               valid_d    = 1'b1;
               wait_cnt_d = 4'd0;
               state_d    = HOLD;
            end else if (wait_cnt_q == 4'd15) begin
               valid_d = 1'b0;
               err_d   = 1'b1;
               state_d = ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         HOLD: begin
            valid_d = 1'b1;
            if (PC_LdEn) begin
               pc_d    = next_pc_s;
               valid_d = 1'b0;
               state_d = REQ;
            end else begin
               state_d = HOLD;
            end
         end
         ERR: begin
            valid_d = 1'b0;
            err_d   = 1'b1;
            state_d = ERR;
         end
         default: begin
            state_d    = IDLE;
            valid_d    = 1'b0;
            wait_cnt_d = 4'd0;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         pc_q       <= 32'h0000_0000;
         instr_q    <= 32'h0000_0000;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         wait_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Request decodes straight from state so an async reset drops it at once.
   assign imem.Imem_Req  = (state_q == REQ);
   assign imem.Imem_Addr = pc_q;
   assign PC             = pc_q;
   assign Instr          = instr_q;
   assign Instr_Valid    = valid_q;
   assign Fetch_Err      = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run, all checked
// against a behavioural model of the fetch rules.
module tb_instr_fetch;
   logic        Clk = 1'b0;
   logic        Reset;
   logic        PC_Sel;
   logic        PC_LdEn;
   logic [31:0] PC_Immed;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic        Instr_Valid;
   logic        Fetch_Err;

   int checks = 0;
   int passes = 0;

   instr_fetch_if bus ();

   instr_fetch dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .PC_Sel      (PC_Sel),
      .PC_LdEn     (PC_LdEn),
      .PC_Immed    (PC_Immed),
      .imem        (bus),
      .PC          (PC),
      .Instr       (Instr),
      .Instr_Valid (Instr_Valid),
      .Fetch_Err   (Fetch_Err)
   );

   always #5 Clk = ~Clk;

   // Behavioural model: what the fetch unit is doing, not how it is built.
   typedef enum {M_IDLE, M_WAIT, M_HAVE, M_DEAD} mphase_e;
   mphase_e     m_phase;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   bit          m_valid;
   bit          m_err;
   int          m_waited;

   task automatic model_reset();
      m_phase  = M_IDLE;
      m_pc     = 32'h0;
      m_instr  = 32'h0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      m_waited = 0;
   endtask

   task automatic model_edge();
      longint target;
      case (m_phase)
         M_IDLE: begin
            m_phase  = M_WAIT;
            m_waited = 0;
         end
         M_WAIT: begin
            if (bus.Imem_Ack) begin
               m_instr = bus.Imem_Data;
               m_valid = 1'b1;
               m_phase = M_HAVE;
            end else begin
               m_waited++;
               if (m_waited >= 16) begin
                  m_phase = M_DEAD;
                  m_err   = 1'b1;
               end
            end
         end
         M_HAVE: begin
            if (PC_LdEn) begin
               target = longint'(m_pc) + 64'sd4;
               if (PC_Sel) target = target + longint'($signed(PC_Immed)) * 64'sd4;
               m_pc     = target[31:0];
               m_valid  = 1'b0;
               m_waited = 0;
               m_phase  = M_WAIT;
            end
         end
         default: ;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes = passes + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/pc"},    PC,                     m_pc);
      chk({tag, "/addr"},  bus.Imem_Addr,          m_pc);
      chk({tag, "/req"},   {31'd0, bus.Imem_Req},  {31'd0, m_phase == M_WAIT});
      chk({tag, "/instr"}, Instr,                  m_instr);
      chk({tag, "/valid"}, {31'd0, Instr_Valid},   {31'd0, m_valid});
      chk({tag, "/err"},   {31'd0, Fetch_Err},     {31'd0, m_err});
   endtask

   // One clock: model follows the rules at the edge, DUT is sampled 1 time unit later.
   task automatic cycle(input string tag);
      @(posedge Clk);
      if (!Reset) model_reset();
      else model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic fetch_ack(input logic [31:0] data);
      bus.Imem_Ack  = 1'b1;
      bus.Imem_Data = data;
      cycle("fetch");
      bus.Imem_Ack  = 1'b0;
   endtask

   task automatic advance(input logic sel, input logic [31:0] immed);
      PC_LdEn  = 1'b1;
      PC_Sel   = sel;
      PC_Immed = immed;
      cycle("advance");
      PC_LdEn  = 1'b0;
   endtask

   task automatic restart();
      Reset = 1'b0;
      #2;
      model_reset();
      Reset = 1'b1;
      cycle("restart");
   endtask

   initial begin
      Reset         = 1'b0;
      PC_Sel        = 1'b0;
      PC_LdEn       = 1'b0;
      PC_Immed      = 32'h0;
      bus.Imem_Ack  = 1'b0;
      bus.Imem_Data = 32'h0;
      model_reset();
      #1;
      check_all("reset");
      cycle("reset_hold");
      cycle("reset_hold2");

      // First fetch from address 0 with a zero-wait acknowledge.
      Reset = 1'b1;
      cycle("first_req");
      chk("first_req_hi", {31'd0, bus.Imem_Req}, 32'd1);
      fetch_ack(32'h8000_0003);
      chk("zero_wait_instr", Instr, 32'h8000_0003);
      chk("zero_wait_pc", PC, 32'h0);

      // Walk sequentially to 0x10, then step once more.
      for (int i = 0; i < 4; i++) begin
         advance(1'b0, 32'h0);
         fetch_ack($urandom);
      end
      chk("at_0x10", PC, 32'h10);
      advance(1'b0, 32'h0);
      chk("seq_pc", PC, 32'h14);
      chk("seq_addr", bus.Imem_Addr, 32'h14);
      chk("seq_invalid", {31'd0, Instr_Valid}, 32'd0);
      fetch_ack($urandom);

      // Branches backward and forward from 0x20.
      for (int i = 0; i < 3; i++) begin
         advance(1'b0, 32'h0);
         fetch_ack($urandom);
      end
      advance(1'b1, 32'hFFFF_FFFE);
      chk("br_back", PC, 32'h1C);
      fetch_ack($urandom);
      advance(1'b0, 32'h0);
      fetch_ack($urandom);
      advance(1'b1, 32'h0000_0003);
      chk("br_fwd", PC, 32'h30);
      fetch_ack($urandom);

      // Randomized control and memory behaviour.
      for (int i = 0; i < 300; i++) begin
         PC_LdEn       = ($urandom_range(0, 3) == 0);
         PC_Sel        = 1'($urandom_range(0, 1));
         PC_Immed      = $urandom;
         bus.Imem_Ack  = ($urandom_range(0, 3) != 0);
         bus.Imem_Data = $urandom;
         cycle("rand");
      end
      PC_LdEn      = 1'b0;
      bus.Imem_Ack = 1'b0;

      // Ack on the last allowed wait cycle, then wrap the PC past 2^32.
      restart();
      fetch_ack(32'h1234_5678);
      advance(1'b1, 32'hFFFF_FFFE);
      chk("pc_top", PC, 32'hFFFF_FFFC);
      for (int i = 0; i < 15; i++) cycle("slow_wait");
      fetch_ack(32'hCAFE_F00D);
      chk("late_ack_err", {31'd0, Fetch_Err}, 32'd0);
      chk("late_ack_instr", Instr, 32'hCAFE_F00D);
      advance(1'b0, 32'h0);
      chk("wrap_pc", PC, 32'h0);

      // Sixteen unanswered edges: sticky error, everything else frozen.
      for (int i = 0; i < 16; i++) cycle("timeout_wait");
      chk("timeout_err", {31'd0, Fetch_Err}, 32'd1);
      chk("timeout_req", {31'd0, bus.Imem_Req}, 32'd0);
      PC_LdEn      = 1'b1;
      bus.Imem_Ack = 1'b1;
      for (int i = 0; i < 4; i++) cycle("err_frozen");
      chk("err_pc_frozen", PC, 32'h0);
      PC_LdEn      = 1'b0;
      bus.Imem_Ack = 1'b0;

      // Reset in the middle of a pending request drops Req without a clock edge.
      restart();
      cycle("pre_abort");
      chk("pre_abort_req", {31'd0, bus.Imem_Req}, 32'd1);
      #2;
      Reset = 1'b0;
      model_reset();
      #1;
      chk("abort_req_now", {31'd0, bus.Imem_Req}, 32'd0);
      check_all("abort");
      bus.Imem_Ack  = 1'b1;
      bus.Imem_Data = 32'hDEAD_BEEF;
      cycle("abort_ack_ignored");
      bus.Imem_Ack  = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
